// File: rtl/vector_fetch_if.sv
// Point-RAM read bus plus the point valid/ready handshake toward the beam/line stage.
// master = vector_fetch, slave = RAM model and downstream consumer.
interface vector_fetch_if #(
  parameter int ADDRESSWIDTH = 16,
  parameter int DATAWIDTH    = 18,
  parameter int OUT_WIDTH    = 8
);
  logic [ADDRESSWIDTH-1:0] addr;
  logic [DATAWIDTH-1:0]    data_in;
  logic [OUT_WIDTH-1:0]    pt_x;
  logic [OUT_WIDTH-1:0]    pt_y;
  logic                    pt_draw;
  logic                    pt_valid;
  logic                    pt_ready;

  modport master (
    output addr, pt_x, pt_y, pt_draw, pt_valid,
    input  data_in, pt_ready
  );

  modport slave (
    input  addr, pt_x, pt_y, pt_draw, pt_valid,
    output data_in, pt_ready
  );
endinterface

// File: rtl/vector_fetch.sv
// Frame-list reader: walks the point RAM after a go edge, emits (x, y, draw) points
// over valid/ready, and pulses halt at the end marker or the MAX_POINTS limit.
//
// state   | meaning
// IDLE    | waiting for a go rising edge, addr parked at 0
// READ    | addr holds current index, RAM read in flight
// DECODE  | data_in valid, classify word
// HOLD    | point presented, waiting for pt_ready
// ADVANCE | step index or stop at MAX_POINTS
// DONE    | frame finished, schedule halt pulse and park addr
module vector_fetch #(
  parameter int ADDRESSWIDTH = 16,
  parameter int DATAWIDTH    = 18,
  parameter int OUT_WIDTH    = 8,
  parameter int MAX_POINTS   = 1000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          go,
  output logic          halt,
  output logic          busy,
  output logic          overrun,
  vector_fetch_if.master bus
);

  typedef enum logic [2:0] {IDLE, READ, DECODE, HOLD, ADVANCE, DONE} state_t;

  localparam logic [ADDRESSWIDTH:0] LIMIT = MAX_POINTS[ADDRESSWIDTH:0];
  localparam logic [ADDRESSWIDTH:0] ONE   = {{ADDRESSWIDTH{1'b0}}, 1'b1};

  state_t                  state, state_next;
  logic                    go_q;
  logic                    start;
  logic [1:0]              word_type;
  logic [ADDRESSWIDTH:0]   index_next;
  logic                    at_limit;

  logic [ADDRESSWIDTH-1:0] addr_d;
  logic [OUT_WIDTH-1:0]    x_d, y_d;
  logic                    draw_d, valid_d, halt_d, overrun_d;

  assign start      = go & ~go_q;
  assign word_type  = bus.data_in[DATAWIDTH-1 -: 2];
  // One extra bit so the limit compare works even when MAX_POINTS == 2^ADDRESSWIDTH.
  assign index_next = {1'b0, bus.addr} + ONE;
  assign at_limit   = (index_next == LIMIT);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = READ;
      READ:    state_next = DECODE;
      DECODE: begin
        if (word_type == 2'b11)      state_next = DONE;
        else if (word_type == 2'b10) state_next = ADVANCE;
        else                         state_next = HOLD;
      end
      HOLD:    if (bus.pt_valid && bus.pt_ready) state_next = ADVANCE;
      ADVANCE: state_next = at_limit ? DONE : READ;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    addr_d    = bus.addr;
    x_d       = bus.pt_x;
    y_d       = bus.pt_y;
    draw_d    = bus.pt_draw;
    valid_d   = bus.pt_valid;
    halt_d    = 1'b0;
    overrun_d = overrun;
    unique case (state)
      IDLE: begin
        addr_d = '0;
        if (start) overrun_d = 1'b0;
      end
      DECODE: begin
        if (!word_type[1]) begin
          x_d     = bus.data_in[15:8];
          y_d     = bus.data_in[7:0];
          draw_d  = word_type[0];
          valid_d = 1'b1;
        end
      end
      HOLD:    if (bus.pt_ready) valid_d = 1'b0;
      ADVANCE: begin
        if (at_limit) overrun_d = 1'b1;
        else          addr_d    = index_next[ADDRESSWIDTH-1:0];
      end
      DONE: begin
        halt_d = 1'b1;
        addr_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      go_q         <= 1'b0;
      bus.addr     <= '0;
      bus.pt_x     <= '0;
      bus.pt_y     <= '0;
      bus.pt_draw  <= 1'b0;
      bus.pt_valid <= 1'b0;
      halt         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      go_q         <= go;
      bus.addr     <= addr_d;
      bus.pt_x     <= x_d;
      bus.pt_y     <= y_d;
      bus.pt_draw  <= draw_d;
      bus.pt_valid <= valid_d;
      halt         <= halt_d;
      overrun      <= overrun_d;
    end
  end

endmodule

// File: tb/tb_vector_fetch.sv
// Bench for vector_fetch: a frame-walk model predicts the point list and overrun per frame,
// a negedge monitor scores every handshake and halt, directed frames pin cycle timing.
module tb_vector_fetch;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic       draw;
  } pt_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  vector_fetch_if #(.ADDRESSWIDTH(16), .DATAWIDTH(18), .OUT_WIDTH(8)) bus_a ();
  vector_fetch_if #(.ADDRESSWIDTH(16), .DATAWIDTH(18), .OUT_WIDTH(8)) bus_b ();

  logic go_a = 1'b0, go_b = 1'b0;
  logic halt_a, busy_a, ovr_a, halt_b, busy_b, ovr_b;
  logic [17:0] mem_a [16];
  logic [17:0] mem_b [16];

  vector_fetch #(.ADDRESSWIDTH(16), .DATAWIDTH(18), .OUT_WIDTH(8), .MAX_POINTS(1000)) dut_a (
    .clk(clk), .rst(rst), .go(go_a), .halt(halt_a), .busy(busy_a), .overrun(ovr_a), .bus(bus_a)
  );
  vector_fetch #(.ADDRESSWIDTH(16), .DATAWIDTH(18), .OUT_WIDTH(8), .MAX_POINTS(4)) dut_b (
    .clk(clk), .rst(rst), .go(go_b), .halt(halt_b), .busy(busy_b), .overrun(ovr_b), .bus(bus_b)
  );

  always @(posedge clk) bus_a.data_in <= mem_a[bus_a.addr[3:0]];
  always @(posedge clk) bus_b.data_in <= mem_b[bus_b.addr[3:0]];

  function automatic logic [17:0] w(input logic [1:0] t, input logic [7:0] x, input logic [7:0] y);
    return {t, x, y};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: walk the frame list up to MAX_POINTS words, dropping reserved words.
  pt_t exp_a[$], exp_b[$];
  bit  eovr_a, eovr_b;

  task automatic build(input bit which, input int maxp);
    logic [17:0] wd;
    bit ended;
    pt_t p;
    ended = 0;
    if (which) exp_b.delete(); else exp_a.delete();
    for (int i = 0; i < maxp && i < 16 && !ended; i++) begin
      wd = which ? mem_b[i] : mem_a[i];
      if (wd[17:16] == 2'b11) ended = 1;
      else if (wd[17:16] != 2'b10) begin
        p = '{x: wd[15:8], y: wd[7:0], draw: wd[16]};
        if (which) exp_b.push_back(p); else exp_a.push_back(p);
      end
    end
    if (which) eovr_b = !ended; else eovr_a = !ended;
  endtask

  // Monitor for the long-frame instance.
  int   acc_a[$];
  int   halts_a = 0, stall_a = 0, halt_cyc_a = 0;
  bit   hold_prev_a = 0, halt_prev_a = 0;
  pt_t  cur_a, last_a, e_a;
  logic [15:0] last_addr_a;

  always @(negedge clk) begin
    if (rst) begin
      hold_prev_a = 0;
      halt_prev_a = 0;
    end else begin
      cur_a = '{x: bus_a.pt_x, y: bus_a.pt_y, draw: bus_a.pt_draw};
      if (hold_prev_a) begin
        chk("stall_valid_a", 32'(bus_a.pt_valid), 32'd1);
        chk("stall_point_a", 32'(cur_a), 32'(last_a));
        chk("stall_addr_a", 32'(bus_a.addr), 32'(last_addr_a));
      end
      if (bus_a.pt_valid && bus_a.pt_ready) begin
        if (exp_a.size() == 0) chk("unexpected_point_a", 32'(cur_a), 32'h1ffff);
        else begin
          e_a = exp_a.pop_front();
          chk("point_a", 32'(cur_a), 32'(e_a));
        end
        acc_a.push_back(cyc);
      end
      if (bus_a.pt_valid && !bus_a.pt_ready) stall_a++;
      hold_prev_a = bus_a.pt_valid && !bus_a.pt_ready;
      last_a      = cur_a;
      last_addr_a = bus_a.addr;
      if (halt_a) begin
        chk("halt_single_a", 32'(halt_prev_a), 32'd0);
        chk("halt_points_left_a", 32'(exp_a.size()), 32'd0);
        chk("halt_overrun_a", 32'(ovr_a), 32'(eovr_a));
        halts_a++;
        halt_cyc_a = cyc;
      end
      halt_prev_a = halt_a;
    end
  end

  // Monitor for the MAX_POINTS=4 instance.
  int  acc_b[$];
  int  halts_b = 0, halt_cyc_b = 0;
  pt_t cur_b, e_b;

  always @(negedge clk) begin
    if (!rst) begin
      cur_b = '{x: bus_b.pt_x, y: bus_b.pt_y, draw: bus_b.pt_draw};
      if (bus_b.pt_valid && bus_b.pt_ready) begin
        if (exp_b.size() == 0) chk("unexpected_point_b", 32'(cur_b), 32'h1ffff);
        else begin
          e_b = exp_b.pop_front();
          chk("point_b", 32'(cur_b), 32'(e_b));
        end
        acc_b.push_back(cyc);
      end
      if (halt_b) begin
        chk("halt_points_left_b", 32'(exp_b.size()), 32'd0);
        chk("halt_overrun_b", 32'(ovr_b), 32'(eovr_b));
        halts_b++;
        halt_cyc_b = cyc;
      end
    end
  end

  task automatic load_frame1();
    for (int i = 0; i < 16; i++) mem_a[i] = '0;
    mem_a[0] = w(2'b00, 8'd10, 8'd20);
    mem_a[1] = w(2'b01, 8'd200, 8'd20);
    mem_a[2] = w(2'b01, 8'd200, 8'd200);
    mem_a[3] = w(2'b11, 8'd0, 8'd0);
  endtask

  task automatic start_a(output int c0);
    build(1'b0, 1000);
    go_a = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    acc_a.delete();
    halts_a = 0;
    stall_a = 0;
    go_a = 1'b1;
    c0 = cyc;
  endtask

  task automatic wait_halt_a(input int budget);
    int n = 0;
    while (!halt_a && n < budget) begin @(posedge clk); #1; n++; end
    if (!halt_a) chk("halt_timeout_a", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_valid_a(input int budget);
    int n = 0;
    while (!bus_a.pt_valid && n < budget) begin @(posedge clk); #1; n++; end
    if (!bus_a.pt_valid) chk("valid_timeout_a", 32'd0, 32'd1);
  endtask

  int c0, n;

  initial begin
    bus_a.pt_ready = 1'b1;
    bus_b.pt_ready = 1'b1;
    load_frame1();
    for (int i = 0; i < 16; i++) mem_b[i] = w(2'b01, 8'(i * 10), 8'(i * 20 + 1));

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", 32'(bus_a.addr), 32'd0);
    chk("rst_x", 32'(bus_a.pt_x), 32'd0);
    chk("rst_y", 32'(bus_a.pt_y), 32'd0);
    chk("rst_draw", 32'(bus_a.pt_draw), 32'd0);
    chk("rst_valid", 32'(bus_a.pt_valid), 32'd0);
    chk("rst_halt", 32'(halt_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_overrun", 32'(ovr_a), 32'd0);
    rst = 1'b0;

    // Basic frame: points at +3, +7, +11 after the go edge, halt at +16.
    start_a(c0);
    wait_halt_a(100);
    chk("f1_points", 32'(acc_a.size()), 32'd3);
    if (acc_a.size() == 3) begin
      chk("f1_first_lat", 32'(acc_a[0] - c0), 32'd3);
      chk("f1_gap1", 32'(acc_a[1] - acc_a[0]), 32'd4);
      chk("f1_gap2", 32'(acc_a[2] - acc_a[1]), 32'd4);
    end
    chk("f1_halt_lat", 32'(halt_cyc_a - c0), 32'd16);
    chk("f1_halts", 32'(halts_a), 32'd1);

    // go still high: no second frame.
    n = 0;
    repeat (20) begin @(posedge clk); #1; if (busy_a) n++; end
    chk("no_restart_busy", 32'(n), 32'd0);
    chk("no_restart_halts", 32'(halts_a), 32'd1);

    // Point 2 stalled for 7 cycles.
    start_a(c0);
    n = 0;
    while (acc_a.size() < 1 && n < 50) begin @(posedge clk); #1; n++; end
    bus_a.pt_ready = 1'b0;
    wait_valid_a(50);
    repeat (7) @(posedge clk);
    #1;
    bus_a.pt_ready = 1'b1;
    wait_halt_a(100);
    chk("stall_points", 32'(acc_a.size()), 32'd3);
    chk("stall_cycles", 32'(stall_a), 32'd7);
    if (acc_a.size() == 3) chk("stall_gap", 32'(acc_a[1] - acc_a[0]), 32'd11);
    chk("stall_halt_lat", 32'(halt_cyc_a - c0), 32'd23);

    // Empty frame.
    mem_a[0] = w(2'b11, 8'd0, 8'd0);
    start_a(c0);
    wait_halt_a(100);
    chk("empty_points", 32'(acc_a.size()), 32'd0);
    chk("empty_halt_lat", 32'(halt_cyc_a - c0), 32'd4);

    // Reserved word at address 1 is skipped.
    mem_a[0] = w(2'b00, 8'd1, 8'd2);
    mem_a[1] = w(2'b10, 8'd99, 8'd99);
    mem_a[2] = w(2'b01, 8'd3, 8'd4);
    mem_a[3] = w(2'b11, 8'd0, 8'd0);
    start_a(c0);
    wait_halt_a(100);
    chk("resv_points", 32'(acc_a.size()), 32'd2);
    if (acc_a.size() == 2) chk("resv_gap", 32'(acc_a[1] - acc_a[0]), 32'd7);
    chk("resv_halt_lat", 32'(halt_cyc_a - c0), 32'd15);

    // Reset while holding a point.
    load_frame1();
    bus_a.pt_ready = 1'b0;
    start_a(c0);
    wait_valid_a(50);
    rst = 1'b1;
    @(posedge clk); #1;
    exp_a.delete();
    chk("mid_rst_valid", 32'(bus_a.pt_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy_a), 32'd0);
    chk("mid_rst_addr", 32'(bus_a.addr), 32'd0);
    chk("mid_rst_halt", 32'(halt_a), 32'd0);
    go_a = 1'b0;
    rst = 1'b0;
    halts_a = 0;
    repeat (6) @(posedge clk);
    #1;
    chk("mid_rst_no_halt", 32'(halts_a), 32'd0);
    bus_a.pt_ready = 1'b1;
    start_a(c0);
    wait_halt_a(100);
    chk("post_rst_points", 32'(acc_a.size()), 32'd3);
    chk("post_rst_halt_lat", 32'(halt_cyc_a - c0), 32'd16);

    // MAX_POINTS=4 without end marker: 4 points, halt at +18 with overrun.
    build(1'b1, 4);
    go_b = 1'b1;
    c0 = cyc;
    n = 0;
    while (!halt_b && n < 100) begin @(posedge clk); #1; n++; end
    if (!halt_b) chk("halt_timeout_b", 32'd0, 32'd1);
    @(posedge clk); #1;
    chk("ovr_points", 32'(acc_b.size()), 32'd4);
    chk("ovr_halt_lat", 32'(halt_cyc_b - c0), 32'd18);
    chk("ovr_sticky", 32'(ovr_b), 32'd1);

    mem_b[0] = w(2'b11, 8'd0, 8'd0);
    build(1'b1, 4);
    go_b = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    go_b = 1'b1;
    @(posedge clk); #1;
    chk("ovr_cleared_on_start", 32'(ovr_b), 32'd0);
    n = 0;
    while (!halt_b && n < 100) begin @(posedge clk); #1; n++; end
    if (!halt_b) chk("halt_timeout_b2", 32'd0, 32'd1);
    @(posedge clk); #1;
    chk("b_halts", 32'(halts_b), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
